// File: rtl/ysyx_25030093_lsu.sv
// ysyx_25030093_lsu: multi-cycle RV32 load/store sequencer between the EXU and a valid/ready data memory
module ysyx_25030093_lsu #(
  parameter logic [31:0] ADDR_LO = 32'h8000_0000,
  parameter logic [31:0] ADDR_HI = 32'h87ff_ffff,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_resp_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic wen_q, wen_d, err_q, err_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, bad, timeout;
  logic [31:0] word, ld;
  always_comb begin
    accept = state_q == IDLE && req_valid;
    bad = (req_wen ? req_funct3 >= 3'd3 : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11)) ||
          (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) ||
          req_addr < ADDR_LO || req_addr > ADDR_HI;
    timeout = cnt_q == CW'(TIMEOUT_CYC - 1);
    word = mem_resp_rdata >> {addr_q[1:0], 3'b000};
    ld = f3_q[1] ? word :
         f3_q[0] ? {{16{~f3_q[2] & word[15]}}, word[15:0]} :
                   {{24{~f3_q[2] & word[7]}}, word[7:0]};
    wen_d = accept ? req_wen : wen_q;
    f3_d = accept ? req_funct3 : f3_q;
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
    rdata_d = accept ? '0 : (state_q == WAIT && mem_resp_valid && !wen_q) ? ld : rdata_q;
    err_d = accept ? bad : state_q == WAIT ? (mem_resp_valid ? 1'b0 : (timeout | err_q)) : err_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = req_valid ? (bad ? RESP : ISSUE) : IDLE;
      ISSUE: state_d = mem_req_ready ? WAIT : ISSUE;
      WAIT:  state_d = (mem_resp_valid || timeout) ? RESP : WAIT;
      RESP:  state_d = resp_ready ? IDLE : RESP;
    endcase
  end
  always_comb begin
    req_ready = state_q == IDLE;
    mem_req_valid = state_q == ISSUE;
    mem_resp_ready = state_q == WAIT;
    resp_valid = state_q == RESP;
    mem_we = mem_req_valid & wen_q;
    mem_addr = mem_req_valid ? {addr_q[31:2], 2'b00} : '0;
    mem_wstrb = !mem_we ? 4'b0000 : f3_q[1] ? 4'b1111 :
                f3_q[0] ? 4'b0011 << addr_q[1:0] : 4'b0001 << addr_q[1:0];
    mem_wdata = !mem_we ? '0 : f3_q[1] ? wdata_q :
                f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err = resp_valid & err_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wen_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wen_q <= wen_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// tb_ysyx_25030093_lsu: directed and randomized self-checking bench for the load/store sequencer
module tb_ysyx_25030093_lsu;
  localparam int TO = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
  logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_resp_rdata = '0;
  logic req_ready, resp_valid, resp_err, mem_req_valid, mem_we, mem_resp_ready;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  int errors = 0, checks = 0;

  ysyx_25030093_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic w, input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = 1 << f[1:0];
    return (w ? f >= 3'd3 : (f == 3'd3 || f >= 3'd6)) || (a % 32'(sz) != 0) ||
           a < 32'h8000_0000 || a > 32'h87ff_ffff;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] s, v;
    s = w >> (8 * off);
    if (f == 3'd2) v = s;
    else if (f[0]) begin
      v = s & 32'hFFFF;
      if (f == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = s & 32'hFF;
      if (f == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end
    return v;
  endfunction

  function automatic logic [3:0] strb_of(input logic [2:0] f, input logic [1:0] off);
    int sz;
    sz = 1 << f[1:0];
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f, input logic [31:0] d);
    int sz;
    logic [31:0] r;
    sz = 1 << f[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  // transaction-level reference: what is outstanding and what the answer must be
  bit m_on = 0, m_busy = 0, m_need_mem = 0, m_in_mem = 0, m_have_resp = 0;
  int m_wait = 0, mem_hs = 0;
  logic m_wen = 1'b0, e_err = 1'b0;
  logic [2:0] m_f3 = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, e_rdata = '0;

  always @(negedge clock) begin
    if (m_on) begin
      chk("req_ready", req_ready, !m_busy);
      chk("mem_req_valid", mem_req_valid, m_need_mem);
      if (m_need_mem) begin
        chk("mem_we", mem_we, m_wen);
        chk("mem_addr", mem_addr, m_addr & ~32'h3);
        chk("mem_wstrb", mem_wstrb, m_wen ? strb_of(m_f3, m_addr[1:0]) : 4'h0);
        if (m_wen) chk("mem_wdata", mem_wdata, wdata_of(m_f3, m_wdata));
      end
      chk("mem_resp_ready", mem_resp_ready, m_in_mem);
      chk("resp_valid", resp_valid, m_have_resp);
      if (m_have_resp) begin
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_err", resp_err, e_err);
      end
    end
    if (reset) begin
      m_on = 1; m_busy = 0; m_need_mem = 0; m_in_mem = 0; m_have_resp = 0; m_wait = 0;
    end else if (m_on) begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy = 1; m_wen = req_wen; m_f3 = req_funct3; m_addr = req_addr; m_wdata = req_wdata;
          if (is_bad(req_wen, req_funct3, req_addr)) begin
            m_have_resp = 1; e_err = 1'b1; e_rdata = '0;
          end else m_need_mem = 1;
        end
      end else if (m_need_mem) begin
        if (mem_req_ready) begin
          m_need_mem = 0; m_in_mem = 1; m_wait = 0; mem_hs++;
        end
      end else if (m_in_mem) begin
        m_wait++;
        if (mem_resp_valid) begin
          m_in_mem = 0; m_have_resp = 1; e_err = 1'b0;
          e_rdata = m_wen ? 32'h0 : load_val(m_f3, m_addr[1:0], mem_resp_rdata);
        end else if (m_wait == TO) begin
          m_in_mem = 0; m_have_resp = 1; e_err = 1'b1; e_rdata = '0;
        end
      end else if (resp_ready) begin
        m_have_resp = 0; m_busy = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] rd, wd, ma;
  logic er;
  logic [3:0] st;
  int nm, lat, hs0, nw;

  // zero-wait memory transaction; reports response, last memory request seen and latency
  task automatic run_op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] word);
    int n;
    nm = 0; st = '0; wd = '0; ma = '0;
    req_wen = w; req_funct3 = f; req_addr = a; req_wdata = d; mem_resp_rdata = word;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; resp_ready = 1'b0; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      if (mem_req_valid) begin nm++; st = mem_wstrb; wd = mem_wdata; ma = mem_addr; end
      tick;
      n++;
    end
    lat = n;
    chk("resp_arrives", resp_valid, 1'b1);
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
  endtask

  initial begin
    repeat (2) tick;
    reset = 1'b0;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_resp_ready", mem_resp_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    tick;

    run_op(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF);
    chk("lw_rdata", rd, 32'hDEAD_BEEF); chk("lw_err", er, 1'b0); chk("lw_latency", lat, 2);
    run_op(1'b0, 3'd0, 32'h8000_0013, 32'h0, 32'h80FF_0000);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    run_op(1'b0, 3'd4, 32'h8000_0013, 32'h0, 32'h80FF_0000);
    chk("lbu_rdata", rd, 32'h0000_0080);
    run_op(1'b0, 3'd5, 32'h8000_0012, 32'h0, 32'h80FF_0000);
    chk("lhu_rdata", rd, 32'h0000_80FF);
    run_op(1'b1, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555);
    chk("sh_wstrb", st, 4'b1100); chk("sh_wdata", wd, 32'hABCD_ABCD);
    chk("sh_addr", ma, 32'h8000_0000); chk("sh_rdata", rd, 32'h0); chk("sh_err", er, 1'b0);
    run_op(1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h1111_1111);
    chk("lw_misal_err", er, 1'b1); chk("lw_misal_nomem", nm, 0); chk("lw_misal_rdata", rd, 32'h0);
    run_op(1'b1, 3'd0, 32'h7FFF_FFFF, 32'hFF, 32'h1111_1111);
    chk("sb_window_err", er, 1'b1); chk("sb_window_nomem", nm, 0);

    // backpressure on both sides
    hs0 = mem_hs;
    req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0020; mem_resp_rdata = 32'h1122_3344;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; resp_ready = 1'b0; req_valid = 1'b1;
    tick;
    req_addr = 32'h8000_0100;
    repeat (5) begin
      chk("bp_mem_valid", mem_req_valid, 1'b1); chk("bp_mem_addr", mem_addr, 32'h8000_0020);
      chk("bp_mem_wstrb", mem_wstrb, 4'h0); chk("bp_req_ready", req_ready, 1'b0);
      tick;
    end
    mem_req_ready = 1'b1;
    tick;
    chk("bp_wait", mem_resp_ready, 1'b1);
    tick;
    repeat (3) begin
      chk("bp_resp_valid", resp_valid, 1'b1); chk("bp_resp_rdata", resp_rdata, 32'h1122_3344);
      chk("bp_resp_err", resp_err, 1'b0); chk("bp_req_ready", req_ready, 1'b0);
      tick;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("bp_idle", req_ready, 1'b1); chk("bp_one_hs", mem_hs - hs0, 1);

    // timeout with a silent memory
    req_funct3 = 3'd2; req_addr = 32'h8000_0040; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    nw = 0; nm = 0;
    while (!resp_valid && nm < 20) begin
      if (mem_resp_ready) nw++;
      tick;
      nm++;
    end
    chk("to_wait_cycles", nw, TO); chk("to_err", resp_err, 1'b1); chk("to_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;

    // reset while waiting, then a late memory response
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    chk("rw_in_wait", mem_resp_ready, 1'b1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rw_req_ready", req_ready, 1'b1); chk("rw_resp_ready", mem_resp_ready, 1'b0);
    chk("rw_resp_valid", resp_valid, 1'b0);
    mem_resp_valid = 1'b1;
    tick;
    chk("late_resp_ignored", resp_valid, 1'b0);

    // randomized traffic against the reference
    hs0 = mem_hs;
    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom % 2);
      req_wen = 1'($urandom % 2);
      req_funct3 = 3'($urandom % 3);
      if (!req_wen && req_funct3 != 3'd2 && $urandom % 2 == 0) req_funct3 = req_funct3 | 3'b100;
      if ($urandom % 4 == 0) req_funct3 = 3'($urandom % 8);
      case ($urandom % 8)
        0: req_addr = 32'h7FFF_FFFC + 32'($urandom % 4);
        1: req_addr = 32'h8800_0000 + 32'($urandom % 4);
        2: req_addr = 32'h87FF_FFFC + 32'($urandom % 4);
        default: req_addr = 32'h8000_0000 + 32'($urandom % 64);
      endcase
      req_wdata = $urandom;
      mem_req_ready = 1'($urandom % 3 != 0);
      mem_resp_valid = m_in_mem ? 1'($urandom % 3 == 0) : 1'($urandom % 4 == 0);
      mem_resp_rdata = $urandom;
      resp_ready = 1'($urandom % 2);
      reset = 1'($urandom % 500 == 0);
      tick;
    end
    reset = 1'b0; req_valid = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b1; resp_ready = 1'b1;
    repeat (10) tick;
    chk("rand_drained", req_ready, 1'b1);
    chk("rand_traffic", mem_hs - hs0 > 100, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
